// File: rtl/game_flow_ctrl.sv
// Game sequencing controller: start, per-level round timer, lives, pause/clear
// freezes, game-over and victory. Moore machine; outputs decode from state.
module game_flow_ctrl #(
    parameter int NUM_LIVES   = 3,
    parameter int NUM_LEVELS  = 4,
    parameter int ROUND_TIME  = 100,
    parameter int PAUSE_TICKS = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startKey,
    input  logic       tick,
    input  logic       charHit,
    input  logic       levelCleared,
    output logic       levelStart,
    output logic       freeze,
    output logic [2:0] level,
    output logic [1:0] lives,
    output logic [7:0] timeLeft,
    output logic       gameOver,
    output logic       victory,
    output logic [2:0] state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5,
        S_WIN   = 3'd6
    } state_e;

    localparam logic [1:0] LIVES_INIT = 2'(NUM_LIVES);
    localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);
    localparam logic [7:0] TIME_INIT  = 8'(ROUND_TIME);
    localparam logic [3:0] PAUSE_LAST = 4'(PAUSE_TICKS - 1);

    state_e     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [2:0] level_q, level_d;
    logic [7:0] time_q,  time_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       death;

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state_q <= S_IDLE;
            lives_q <= LIVES_INIT;
            level_q <= 3'd0;
            time_q  <= TIME_INIT;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            level_q <= level_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        time_d  = time_q;
        cnt_d   = cnt_q;
        death   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (startKey) begin
                    state_d = S_LOAD;
                    time_d  = TIME_INIT;
                end
            end
            S_LOAD: begin
                state_d = S_PLAY;
                time_d  = TIME_INIT;
            end
            S_PLAY: begin
                if (tick && time_q != 8'd0) time_d = time_q - 8'd1;
                // A hit wins over a simultaneous clear; timeout is the last tick of the budget.
                death = charHit || (tick && time_q == 8'd1);
                if (death) begin
                    cnt_d = 4'd0;
                    if (lives_q <= 2'd1) begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end else begin
                        lives_d = lives_q - 2'd1;
                        state_d = S_PAUSE;
                    end
                end else if (levelCleared) begin
                    cnt_d   = 4'd0;
                    state_d = (level_q == LAST_LEVEL) ? S_WIN : S_CLEAR;
                end
            end
            S_PAUSE, S_CLEAR: begin
                if (tick) begin
                    if (cnt_q == PAUSE_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = S_LOAD;
                        time_d  = TIME_INIT;
                        if (state_q == S_CLEAR) level_d = level_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_OVER, S_WIN: begin
                if (startKey) begin
                    state_d = S_LOAD;
                    lives_d = LIVES_INIT;
                    level_d = 3'd0;
                    time_d  = TIME_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                lives_d = LIVES_INIT;
                level_d = 3'd0;
                time_d  = TIME_INIT;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        levelStart = 1'b0;
        freeze     = 1'b1;
        gameOver   = 1'b0;
        victory    = 1'b0;
        case (state_q)
            S_LOAD:  begin levelStart = 1'b1; freeze = 1'b0; end
            S_PLAY:  freeze = 1'b0;
            S_OVER:  gameOver = 1'b1;
            S_WIN:   victory = 1'b1;
            default: freeze = 1'b1;
        endcase
    end

    assign level       = level_q;
    assign lives       = lives_q;
    assign timeLeft    = time_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed vector table, hand-written corner
// sequences and random play against a mode-level reference model.
module tb_game_flow_ctrl;

    localparam int NUM_LIVES   = 3;
    localparam int NUM_LEVELS  = 4;
    localparam int ROUND_TIME  = 100;
    localparam int PAUSE_TICKS = 2;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startKey = 1'b0, tick = 1'b0, charHit = 1'b0, levelCleared = 1'b0;
    logic       levelStart, freeze, gameOver, victory;
    logic [2:0] level;
    logic [1:0] lives;
    logic [7:0] timeLeft;
    logic [2:0] dbg_state;

    int total = 0;
    int bad   = 0;

    game_flow_ctrl #(
        .NUM_LIVES(NUM_LIVES), .NUM_LEVELS(NUM_LEVELS),
        .ROUND_TIME(ROUND_TIME), .PAUSE_TICKS(PAUSE_TICKS)
    ) dut (
        .clk(clk), .resetN(resetN), .startKey(startKey), .tick(tick),
        .charHit(charHit), .levelCleared(levelCleared), .levelStart(levelStart),
        .freeze(freeze), .level(level), .lives(lives), .timeLeft(timeLeft),
        .gameOver(gameOver), .victory(victory), .state_dbg_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: game mode plus plain integer counters.
    typedef enum int {M_IDLE, M_LOAD, M_PLAY, M_PAUSE, M_CLEAR, M_OVER, M_WIN} mode_t;
    mode_t m_mode;
    int    m_lives, m_level, m_time, m_ticks;
    logic [16:0] exp_q[$];

    function automatic logic [16:0] mk(bit ls, bit fr, int lvl, int lv, int t, bit go, bit vic);
        return {ls, fr, 3'(lvl), 2'(lv), 8'(t), go, vic};
    endfunction

    function automatic string fmt(logic [16:0] v);
        return $sformatf("ls=%0d fr=%0d lvl=%0d lives=%0d t=%0d go=%0d vic=%0d",
                         v[16], v[15], v[14:12], v[11:10], v[9:2], v[1], v[0]);
    endfunction

    function automatic logic [16:0] model_out();
        return mk(m_mode == M_LOAD, !(m_mode == M_LOAD || m_mode == M_PLAY),
                  m_level, m_lives, m_time, m_mode == M_OVER, m_mode == M_WIN);
    endfunction

    function automatic logic [16:0] dut_out();
        return {levelStart, freeze, level, lives, timeLeft, gameOver, victory};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_lives = NUM_LIVES; m_level = 0; m_time = ROUND_TIME; m_ticks = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit st, input bit tk, input bit hit, input bit clr);
        bit timeout;
        timeout = 1'b0;
        if (m_mode == M_IDLE) begin
            if (st) begin m_mode = M_LOAD; m_time = ROUND_TIME; end
        end else if (m_mode == M_LOAD) begin
            m_mode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            timeout = tk && (m_time == 1);
            if (tk && m_time > 0) m_time = m_time - 1;
            if (hit || timeout) begin
                m_lives = m_lives - 1;
                m_mode  = (m_lives == 0) ? M_OVER : M_PAUSE;
                m_ticks = 0;
            end else if (clr) begin
                m_mode  = (m_level == NUM_LEVELS - 1) ? M_WIN : M_CLEAR;
                m_ticks = 0;
            end
        end else if (m_mode == M_PAUSE || m_mode == M_CLEAR) begin
            if (tk) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == PAUSE_TICKS) begin
                    if (m_mode == M_CLEAR) m_level = m_level + 1;
                    m_mode = M_LOAD;
                    m_time = ROUND_TIME;
                end
            end
        end else begin
            if (st) begin
                m_lives = NUM_LIVES; m_level = 0; m_mode = M_LOAD; m_time = ROUND_TIME;
            end
        end
        exp_q.push_back(model_out());
    endtask

    task automatic check_vec(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = dut_out();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got {%s} want {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare against the model.
    task automatic step(input bit st, input bit tk, input bit hit, input bit clr);
        logic [16:0] e;
        startKey = st; tick = tk; charHit = hit; levelCleared = clr;
        @(posedge clk);
        model_step(st, tk, hit, clr);
        #1;
        e = exp_q.pop_front();
        check_vec("model", e);
    endtask

    task automatic do_reset();
        startKey = 0; tick = 0; charHit = 0; levelCleared = 0;
        resetN = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_vec("reset_state", mk(0, 1, 0, NUM_LIVES, ROUND_TIME, 0, 0));
        resetN = 1'b0;
    endtask

    typedef struct {
        bit st, tk, hit, clr;
        logic [16:0] exp;
    } vec_t;
    vec_t tbl[20];

    task automatic row(input int i, input bit st, input bit tk, input bit hit, input bit clr,
                       input bit ls, input bit fr, input int lvl, input int lv, input int t,
                       input bit go, input bit vic);
        tbl[i].st = st; tbl[i].tk = tk; tbl[i].hit = hit; tbl[i].clr = clr;
        tbl[i].exp = mk(ls, fr, lvl, lv, t, go, vic);
    endtask

    initial begin
        //     i  st tk ht cl  ls fr lvl lv  t   go vic
        row( 0, 1, 0, 0, 0,  1, 0, 0, 3, 100, 0, 0);
        row( 1, 0, 0, 0, 0,  0, 0, 0, 3, 100, 0, 0);
        row( 2, 0, 1, 0, 0,  0, 0, 0, 3,  99, 0, 0);
        row( 3, 0, 0, 1, 1,  0, 1, 0, 2,  99, 0, 0);
        row( 4, 0, 1, 0, 0,  0, 1, 0, 2,  99, 0, 0);
        row( 5, 1, 0, 1, 1,  0, 1, 0, 2,  99, 0, 0);
        row( 6, 0, 1, 0, 0,  1, 0, 0, 2, 100, 0, 0);
        row( 7, 0, 0, 0, 0,  0, 0, 0, 2, 100, 0, 0);
        row( 8, 0, 0, 0, 1,  0, 1, 0, 2, 100, 0, 0);
        row( 9, 0, 1, 0, 0,  0, 1, 0, 2, 100, 0, 0);
        row(10, 0, 1, 0, 0,  1, 0, 1, 2, 100, 0, 0);
        row(11, 0, 0, 0, 0,  0, 0, 1, 2, 100, 0, 0);
        row(12, 0, 0, 1, 0,  0, 1, 1, 1, 100, 0, 0);
        row(13, 0, 1, 0, 0,  0, 1, 1, 1, 100, 0, 0);
        row(14, 0, 1, 0, 0,  1, 0, 1, 1, 100, 0, 0);
        row(15, 0, 0, 0, 0,  0, 0, 1, 1, 100, 0, 0);
        row(16, 0, 0, 1, 0,  0, 1, 1, 0, 100, 1, 0);
        row(17, 0, 1, 0, 1,  0, 1, 1, 0, 100, 1, 0);
        row(18, 1, 0, 0, 0,  1, 0, 0, 3, 100, 0, 0);
        row(19, 0, 0, 0, 0,  0, 0, 0, 3, 100, 0, 0);

        // Directed table: start, hit+clear collision, pause, clear, three deaths, restart.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].st, tbl[i].tk, tbl[i].hit, tbl[i].clr);
            check_vec($sformatf("table_row%0d", i), tbl[i].exp);
        end

        // Timeout: 100 ticks in PLAY, no wrap, death on the last one.
        for (int i = 1; i <= 99; i++) begin
            step(0, 1, 0, 0);
            check_val("timeout_count", int'(timeLeft), ROUND_TIME - i);
        end
        check_val("timeout_lives_before", int'(lives), 3);
        step(0, 1, 0, 0);
        check_val("timeout_zero", int'(timeLeft), 0);
        check_val("timeout_lives", int'(lives), 2);
        check_val("timeout_freeze", int'(freeze), 1);
        step(0, 1, 0, 0);
        check_val("pause_no_start", int'(levelStart), 0);
        step(0, 1, 0, 0);
        check_val("pause_exit_start", int'(levelStart), 1);
        check_val("pause_exit_time", int'(timeLeft), ROUND_TIME);
        step(0, 0, 0, 0);
        check_val("start_one_cycle", int'(levelStart), 0);

        // Walk all levels to victory.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int l = 0; l < NUM_LEVELS - 1; l++) begin
            step(0, 0, 0, 1);
            check_val("clear_level_held", int'(level), l);
            step(0, 1, 0, 0);
            step(0, 1, 0, 0);
            check_val("clear_level_inc", int'(level), l + 1);
            check_val("clear_load_pulse", int'(levelStart), 1);
            step(0, 0, 0, 0);
        end
        step(0, 0, 0, 1);
        check_val("victory", int'(victory), 1);
        check_val("victory_level", int'(level), NUM_LEVELS - 1);
        step(0, 1, 1, 1);
        check_val("victory_hold", int'(victory), 1);
        step(1, 0, 0, 0);
        check_val("victory_restart_level", int'(level), 0);
        check_val("victory_restart_pulse", int'(levelStart), 1);

        // Asynchronous reset during CLEAR with one tick counted.
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        check_vec("pre_reset_clear", mk(0, 1, 1, 2, 99, 0, 0));
        #2;
        resetN = 1'b1;
        #1;
        check_vec("async_reset", mk(0, 1, 0, NUM_LIVES, ROUND_TIME, 0, 0));
        model_reset();
        @(posedge clk);
        #1;
        resetN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0);
            check_val("no_start_after_reset", int'(levelStart), 0);
        end

        // Random play against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
